// File: rtl/usb_status_uart_tx.sv
// usb_status_uart_tx
// Pulls status bytes from the USB status annunciator over the inc/q/dv
// handshake and serializes each one as 8N1 / 8N2 UART on the debug pin.
// Everything runs in the clk48 domain; all outputs except busy are registered.

module usb_status_uart_tx #(
    parameter int unsigned DIVISOR     = 416,  // clk48 cycles per UART bit
    parameter int unsigned STOP_BITS   = 1,    // 1 or 2
    parameter int unsigned REQ_TIMEOUT = 255   // max cycles spent waiting for dv
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic       en,
    output logic       inc,
    input  logic [7:0] q,
    input  logic       dv,
    output logic       tx,
    output logic       busy,
    output logic       byte_sent,
    output logic       req_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Reload value of the bit-period counter and last legal request age.
    localparam logic [15:0] BAUD_LAST = 16'(DIVISOR - 1);
    localparam logic [7:0]  AGE_LAST  = 8'(REQ_TIMEOUT - 1);
    // Index of the final stop bit (0 for one stop bit, 1 for two).
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_e      state_q;
    logic [15:0] baud_q;      // counts DIVISOR-1 down to 0 within each bit
    logic [7:0]  age_q;       // cycles spent in REQ so far
    logic [2:0]  bit_q;       // data bit index, LSB first
    logic        stop_q;      // which stop bit is on the line
    logic [7:0]  shift_q;     // byte being shifted out, shift_q[0] is next
    logic        tx_q;
    logic        inc_q;
    logic        sent_q;
    logic        tmo_q;

    logic        baud_done;
    logic        dv_ok;

    // End of the current bit period, and a dv that belongs to this request
    // (the one seen on the first REQ edge is left over from the last byte).
    always_comb begin
        baud_done = (baud_q == 16'd0);
        dv_ok     = dv && (age_q != 8'd0);
    end

    // Request / frame sequencer with registered line, handshake and pulses.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            age_q   <= 8'd0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            inc_q   <= 1'b0;
            sent_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            tmo_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    inc_q <= 1'b0;
                    if (en) begin
                        state_q <= S_REQ;
                        inc_q   <= 1'b1;
                        age_q   <= 8'd0;
                    end
                end

                // en is deliberately not looked at here: once a byte has
                // been requested it is always taken or timed out.
                S_REQ: begin
                    if (dv_ok) begin
                        shift_q <= q;
                        inc_q   <= 1'b0;
                        baud_q  <= BAUD_LAST;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end else if (age_q == AGE_LAST) begin
                        // Dropping to IDLE guarantees inc is seen low for at
                        // least one cycle before the producer is asked again.
                        inc_q   <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        age_q <= age_q + 8'd1;
                    end
                end

                S_START: begin
                    if (baud_done) begin
                        baud_q  <= BAUD_LAST;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end

                S_DATA: begin
                    if (baud_done) begin
                        baud_q <= BAUD_LAST;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            stop_q  <= 1'b0;
                            state_q <= S_STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end

                S_STOP: begin
                    tx_q <= 1'b1;
                    // Raised one edge early so the registered pulse lands on
                    // the final cycle of the stop period.
                    if (baud_q == 16'd1 && stop_q == STOP_LAST) begin
                        sent_q <= 1'b1;
                    end
                    if (baud_done) begin
                        baud_q <= BAUD_LAST;
                        if (stop_q == STOP_LAST) begin
                            if (en) begin
                                state_q <= S_REQ;
                                inc_q   <= 1'b1;
                                age_q   <= 8'd0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    inc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign inc         = inc_q;
    assign tx          = tx_q;
    assign busy        = (state_q != S_IDLE);
    assign byte_sent   = sent_q;
    assign req_timeout = tmo_q;

endmodule

// File: tb/tb_usb_status_uart_tx.sv
// Bench for usb_status_uart_tx: a producer model answers inc, expected line
// waveforms are built from the byte value and the bit-period arithmetic.

module tb_usb_status_uart_tx;

    localparam int D1 = 4;
    localparam int S1 = 1;
    localparam int T1 = 8;
    localparam int N1 = (9 + S1) * D1;
    localparam int D2 = 3;
    localparam int S2 = 2;
    localparam int N2 = (9 + S2) * D2;

    logic       clk48 = 1'b0;
    logic       rst   = 1'b0;
    logic       en    = 1'b0;
    logic       dv    = 1'b1;
    logic [7:0] q     = 8'h00;
    logic       inc, tx, busy, byte_sent, req_timeout;

    logic       en2   = 1'b0;
    logic       dv2   = 1'b1;
    logic [7:0] q2    = 8'hFF;
    logic       inc2, tx2, busy2, byte_sent2, req_timeout2;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] prod_fifo[$];
    bit         silent = 1'b0;

    always #5 clk48 = ~clk48;

    usb_status_uart_tx #(.DIVISOR(D1), .STOP_BITS(S1), .REQ_TIMEOUT(T1)) u1 (
        .clk48(clk48), .rst(rst), .en(en), .inc(inc), .q(q), .dv(dv),
        .tx(tx), .busy(busy), .byte_sent(byte_sent), .req_timeout(req_timeout)
    );

    usb_status_uart_tx #(.DIVISOR(D2), .STOP_BITS(S2), .REQ_TIMEOUT(255)) u2 (
        .clk48(clk48), .rst(rst), .en(en2), .inc(inc2), .q(q2), .dv(dv2),
        .tx(tx2), .busy(busy2), .byte_sent(byte_sent2), .req_timeout(req_timeout2)
    );

    // Annunciator model: holds dv high, presents a fresh byte one cycle
    // after it sees inc, and re-arms only after inc has been seen low.
    initial begin : producer
        bit   armed;
        logic inc_s;
        armed = 1'b0;
        forever begin
            @(negedge clk48);
            inc_s = inc;
            @(posedge clk48);
            #1;
            if (silent) begin
                dv = 1'b0;
            end else if (inc_s && armed && prod_fifo.size() > 0) begin
                q     = prod_fifo.pop_front();
                dv    = 1'b1;
                armed = 1'b0;
            end else begin
                dv = 1'b1;
                if (!inc_s) armed = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // UART frame as transmitted, index = bit slot: start, 8 data LSB first, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      f[k] = 1'b0;
            else if (k == 9) f[k] = 1'b1;
            else             f[k] = b[k-1];
        end
        return f;
    endfunction

    // Wait for the start bit, then compare every cycle of the frame on u1.
    task automatic run_frame(input string tag, input logic [9:0] pat, input int drop_at, input int exp_lat);
        int   lat  = 0;
        int   errs = 0;
        logic inc1 = 1'b0;
        logic exp_tx;
        do begin
            @(negedge clk48);
            lat++;
            if (lat == 1) inc1 = inc;
        end while (tx !== 1'b0 && lat < 64);
        check({tag, "_inc_rise"}, {31'd0, inc1}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        if (tx !== 1'b0) return;
        for (int i = 0; i < N1; i++) begin
            if (i > 0) @(negedge clk48);
            exp_tx = pat[i / D1];
            if (tx !== exp_tx || byte_sent !== (i == N1 - 1) || inc !== 1'b0 ||
                busy !== 1'b1 || req_timeout !== 1'b0) errs++;
            if (i == drop_at) en = 1'b0;
        end
        check({tag, "_frame"}, errs, 0);
    endtask

    task automatic check_idle(input string tag);
        int bad = 0;
        @(negedge clk48);
        check({tag, "_to_idle"}, {30'd0, inc, busy}, 32'd0);
        repeat (6) begin
            @(negedge clk48);
            if (inc !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check({tag, "_stay_idle"}, bad, 0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [9:0] frame;
        int         drop_at;
        logic       en_after;
    } vec_t;

    initial begin : main
        vec_t vt[4];
        int   nb, drop, lat, e_inc, e_rt, e_tx, errs;
        logic [7:0] rb[$];
        logic [7:0] b;
        logic exp_bit;

        vt[0] = '{8'hA5, 10'h34A, -1, 1'b1};
        vt[1] = '{8'h0C, 10'h218, -1, 1'b1};
        vt[2] = '{8'h41, 10'h282, -1, 1'b1};
        vt[3] = '{8'h3C, 10'h278, 17, 1'b0};   // en drops in data bit 3

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk48);
        check("rst_u1", {27'd0, tx, inc, busy, byte_sent, req_timeout}, 32'h10);
        check("rst_u2", {27'd0, tx2, inc2, busy2, byte_sent2, req_timeout2}, 32'h10);
        rst = 1'b0;
        repeat (2) @(negedge clk48);

        // Table: basic byte, back-to-back stream, disable mid-frame
        for (int i = 0; i < 4; i++) prod_fifo.push_back(vt[i].b);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("vec%0d", i), vt[i].frame, vt[i].drop_at, 3);
            if (!vt[i].en_after) check_idle($sformatf("vec%0d", i));
        end

        // Request timeout: producer never answers
        silent = 1'b1;
        repeat (2) @(negedge clk48);
        en = 1'b1;
        e_inc = 0; e_rt = 0; e_tx = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk48);
            if (inc !== (((k - 1) % 9) != 8)) e_inc++;
            if (req_timeout !== (((k - 1) % 9) == 8)) e_rt++;
            if (tx !== 1'b1) e_tx++;
        end
        check("tmo_inc", e_inc, 0);
        check("tmo_pulse", e_rt, 0);
        check("tmo_tx", e_tx, 0);
        en = 1'b0;
        repeat (12) @(negedge clk48);
        check("tmo_idle", {31'd0, busy}, 32'd0);
        silent = 1'b0;
        repeat (2) @(negedge clk48);

        // Async reset during START
        prod_fifo.push_back(8'h96);
        prod_fifo.push_back(8'h5A);
        en  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk48);
            lat++;
        end while (tx !== 1'b0 && lat < 64);
        check("rst_reach_start", lat, 3);
        #1 rst = 1'b1;
        #1 check("rst_async", {29'd0, tx, inc, busy}, 32'h4);
        #2 rst = 1'b0;
        run_frame("after_rst", model_frame(8'h5A), 0, 3);
        check_idle("after_rst");

        // Random bursts against the frame model
        for (int r = 0; r < 6; r++) begin
            nb = $urandom_range(1, 3);
            rb.delete();
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                rb.push_back(b);
                prod_fifo.push_back(b);
            end
            en = 1'b1;
            for (int j = 0; j < nb; j++) begin
                drop = (j == nb - 1) ? int'($urandom_range(0, N1 - 1)) : -1;
                run_frame($sformatf("rnd%0d_%0d", r, j), model_frame(rb[j]), drop, 3);
            end
            check_idle($sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 4)) @(negedge clk48);
        end

        // Two stop bits on u2, byte 0xFF
        en2 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk48);
            lat++;
        end while (tx2 !== 1'b0 && lat < 64);
        check("stop2_latency", lat, 3);
        errs = 0;
        for (int i = 0; i < N2; i++) begin
            if (i > 0) @(negedge clk48);
            exp_bit = (i >= D2);
            if (tx2 !== exp_bit || byte_sent2 !== (i == N2 - 1) || inc2 !== 1'b0 ||
                busy2 !== 1'b1) errs++;
            if (i == 0) en2 = 1'b0;
        end
        check("stop2_frame", errs, 0);
        @(negedge clk48);
        check("stop2_idle", {29'd0, inc2, busy2, req_timeout2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
